// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
//   state_t  - arbiter sequencing states (IDLE, REQ, WAIT_RSP, DONE)
//   owner_t  - which requester owns the in-flight transaction (OWN_IF, OWN_DM)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: response timeout counter.
//   clk, rst  - clock, synchronous active-high reset
//   load      - restart counting from zero (asserted as WAIT_RSP is entered)
//   en        - count one elapsed cycle; saturates at LIMIT
//   expired   - current cycle is the LIMIT-th cycle since load
module mem_arb_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (load)                        cnt <= '0;
    else if (en && cnt != CW'(LIMIT))     cnt <= cnt + CW'(1);
  end

  // cnt is 0 on the first waiting cycle, so LIMIT-1 marks the LIMIT-th one.
  assign expired = (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port (if_*)
// and the data port (dm_*), one transaction at a time.
//   clk, rst                 - clock, synchronous active-high reset
//   if_req/if_addr           - fetch read request (held until if_done)
//   if_rdata/if_done/if_stall- fetch result, completion pulse, pipeline stall
//   dm_req/dm_we/dm_addr/dm_wdata - data request (held until dm_done)
//   dm_rdata/dm_done/dm_stall- data result, completion pulse, pipeline stall
//   mem_req_*/mem_we/mem_addr/mem_wdata - valid/ready request to memory
//   mem_rsp_valid/mem_rsp_data - one response (or write ack) per request
//   busy                     - a transaction is in flight
//   timeout_err              - sticky, set when a response never arrived
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          busy,
  output logic          timeout_err
);

  if (TIMEOUT < 2 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("mem_port_arbiter: TIMEOUT must be >= 2 and STARVE_LIMIT >= 1");
  end

  state_t        state, state_nxt;
  owner_t        owner;
  logic          any_req, grant_dm, force_if, grant;
  logic          expired, finish;
  logic [DW-1:0] rsp_word;

  assign any_req  = if_req | dm_req;
  assign grant    = (state == IDLE) && any_req;
  assign grant_dm = dm_req && !force_if;
  assign finish   = (state == WAIT_RSP) && (mem_rsp_valid || expired);
  assign rsp_word = mem_rsp_valid ? mem_rsp_data : '0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Counts data grants that left a waiting fetch behind; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= '0;
    else if (grant) begin
      if (!grant_dm)                                    starve_cnt <= '0;
      else if (if_req && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign force_if = if_req && (starve_cnt >= SW'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

  mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    ((state == REQ) && mem_req_ready),
    .en      (state == WAIT_RSP),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    case (state)
      IDLE:     if (any_req) state_nxt = REQ;
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: if (mem_rsp_valid || expired) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request fields are latched at grant so the memory channel never sees
  // live pipeline inputs move underneath an unaccepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_IF;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant) begin
        owner     <= grant_dm ? OWN_DM : OWN_IF;
        mem_we    <= grant_dm && dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end
      if (finish) begin
        if (owner == OWN_DM) dm_rdata <= rsp_word;
        else                 if_rdata <= rsp_word;
        if (!mem_rsp_valid) timeout_err <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign if_done  = (state == DONE) && (owner == OWN_IF);
  assign dm_done  = (state == DONE) && (owner == OWN_DM);
  assign if_stall = if_req && !if_done;
  assign dm_stall = dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-timestamp reference
// model checked every cycle, plus hand-computed latency/data/order checks.
module tb_mem_port_arbiter;

  localparam int AW = 32, DW = 32, TO = 8, SL = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          if_req = 0, dm_req = 0, dm_we = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rsp_data = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, if_stall, dm_done, dm_stall, mem_req_valid, mem_we;
  logic          mem_req_ready = 0, mem_rsp_valid = 0, busy, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder (stimulus only) ----------------
  int            ready_stall = 0;
  bit            rsp_on = 1, stray = 0;
  logic [AW-1:0] acc_addr_q[$];
  bit            acc_we_q[$];

  initial begin
    int stall_left = 0;
    bit acc;
    forever begin
      @(negedge clk);
      acc = (mem_req_valid === 1'b1) && (mem_req_ready === 1'b1);
      if (acc) begin acc_addr_q.push_back(mem_addr); acc_we_q.push_back(mem_we); end
      @(posedge clk); #1;
      mem_rsp_valid = (acc && rsp_on) || stray;
      if (mem_req_valid !== 1'b1) begin stall_left = ready_stall; mem_req_ready = 0; end
      else if (stall_left > 0) begin mem_req_ready = 0; stall_left--; end
      else mem_req_ready = 1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // A transaction is tracked by the cycle it was granted (g), accepted (a)
  // and resolved (r); outputs follow from those timestamps.
  int            cyc = 0, g = 0, a = -1, r = -1, starve = 0;
  bit            mdl_ok = 0, act = 0, m_dm = 0, m_we = 0, m_terr = 0, m_dm_known = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
  bit            p_pend = 0;
  logic [AW-1:0] p_addr = '0;
  bit            done_log[$];

  always @(negedge clk) begin
    bit e_valid, e_ifd, e_dmd, force_if;
    logic [DW-1:0] d;
    if (mdl_ok) begin
      e_valid = act && a < 0 && cyc > g;
      e_ifd   = act && r >= 0 && cyc == r + 1 && !m_dm;
      e_dmd   = act && r >= 0 && cyc == r + 1 && m_dm;
      check("busy", busy, act);
      check("mem_req_valid", mem_req_valid, e_valid);
      check("if_done", if_done, e_ifd);
      check("dm_done", dm_done, e_dmd);
      check("if_stall", if_stall, if_req && !e_ifd);
      check("dm_stall", dm_stall, dm_req && !e_dmd);
      check("timeout_err", timeout_err, m_terr);
      check("if_rdata", if_rdata, m_if_rd);
      if (m_dm_known) check("dm_rdata", dm_rdata, m_dm_rd);
      if (e_valid) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (p_pend) begin
        check("hold_valid", mem_req_valid, 1'b1);
        check("hold_addr", mem_addr, p_addr);
      end
      if (if_done === 1'b1) done_log.push_back(1'b0);
      if (dm_done === 1'b1) done_log.push_back(1'b1);
    end
    p_pend = !rst && mem_req_valid === 1'b1 && mem_req_ready !== 1'b1;
    p_addr = mem_addr;
    // advance the model across the upcoming edge
    if (rst) begin
      mdl_ok = 1; act = 0; a = -1; r = -1; starve = 0; m_terr = 0;
      m_if_rd = '0; m_dm_rd = '0; m_dm_known = 1;
    end else if (mdl_ok) begin
      if (act) begin
        if (r >= 0 && cyc == r + 1) act = 0;
        else if (a < 0) begin
          if (cyc > g && mem_req_ready) a = cyc;
        end else if (r < 0 && cyc > a && (mem_rsp_valid || cyc - a == TO)) begin
          r = cyc;
          d = mem_rsp_valid ? mem_rsp_data : '0;
          if (!mem_rsp_valid) m_terr = 1;
          if (m_dm) begin m_dm_known = !m_we; m_dm_rd = d; end
          else m_if_rd = d;
        end
      end else if (if_req || dm_req) begin
        force_if = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        force_if = if_req && starve >= SL;
`endif
        m_dm = dm_req && !force_if;
        if (!m_dm) starve = 0;
        else if (if_req && starve < SL) starve++;
        act = 1; g = cyc; a = -1; r = -1;
        m_we = m_dm && dm_we;
        m_addr = m_dm ? dm_addr : if_addr;
        m_wdata = dm_wdata;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Latency is counted from the cycle the request was raised (cycle 0).
  task automatic wait_done(input bit dm, input int maxc, output int lat);
    lat = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((dm ? dm_done : if_done) === 1'b1) begin lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, nlog;
    bit exp_order[6];
    step(3);
    check("rst_busy", busy, 0);
    check("rst_valid", mem_req_valid, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    rst = 0;
    step(1);

    // fetch-only read, immediate ready and response
    mem_rsp_data = 32'h00A00093; if_addr = 32'h100; if_req = 1;
    wait_done(0, 10, lat);
    if_req = 0;
    check("fetch_latency", lat, 3);
    check("fetch_data", if_rdata, 32'h00A00093);
    step(2);

    // simultaneous requests: data write first, then fetch
    base = acc_addr_q.size();
    mem_rsp_data = 32'h11111111;
    dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; dm_we = 1; dm_req = 1;
    if_addr = 32'h104; if_req = 1;
    wait_done(1, 10, lat);
    dm_req = 0; dm_we = 0;
    check("dm_first_latency", lat, 3);
    check("if_stall_during_dm", if_stall, 1);
    wait_done(0, 10, lat);
    if_req = 0;
    check("if_second_latency", lat, 3);
    check("if_after_dm_data", if_rdata, 32'h11111111);
    check("first_acc_we", acc_we_q[base], 1);
    check("first_acc_addr", acc_addr_q[base], 32'h10);
    check("second_acc_addr", acc_addr_q[base+1], 32'h104);
    step(2);

    // memory holds off ready for 5 cycles
    ready_stall = 5; mem_rsp_data = 32'h33;
    dm_addr = 32'h20; dm_req = 1;
    wait_done(1, 20, lat);
    dm_req = 0; ready_stall = 0;
    check("stall5_latency", lat, 8);
    check("stall5_data", dm_rdata, 32'h33);
    step(2);

    // no response: timeout after TO waiting cycles, then a stray response
    rsp_on = 0; if_addr = 32'h200; if_req = 1;
    wait_done(0, 30, lat);
    if_req = 0; rsp_on = 1;
    check("timeout_latency", lat, TO + 2);
    check("timeout_data", if_rdata, 0);
    check("timeout_err_set", timeout_err, 1);
    step(1);
    nlog = done_log.size();
    mem_rsp_data = 32'h55; stray = 1;
    step(1);
    stray = 0;
    step(3);
    check("stray_no_done", done_log.size(), nlog);
    check("stray_if_rdata", if_rdata, 0);
    check("stray_busy", busy, 0);

    // reset while waiting for a response
    rsp_on = 0; dm_addr = 32'h30; dm_req = 1;
    step(3);
    rst = 1; dm_req = 0;
    step(1);
    rst = 0; rsp_on = 1;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", mem_req_valid, 0);
    check("rstmid_done", dm_done, 0);
    check("rstmid_terr", timeout_err, 0);
    step(4);
    check("rstmid_no_done", done_log.size(), nlog);

    // both requesters held high for six transactions
    base = done_log.size();
    if_addr = 32'h300; dm_addr = 32'h40; dm_we = 0; if_req = 1; dm_req = 1;
    step(24);
    if_req = 0; dm_req = 0;
    step(3);
    exp_order = '{1, 1, 1, 1, 1, 1};
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_order[4] = 0;
`endif
    check("order_count", done_log.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < done_log.size()) check($sformatf("order_%0d", i), done_log[base+i], exp_order[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
